// File: rtl/bus_timer_if.sv
// bus_timer_if: simple bus between the CPU memory stage and a responder
interface bus_timer_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;
    modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
    modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped timer responder; counts to an expiry value and raises a level interrupt
module bus_timer (
    input  logic       clk,
    input  logic       reset_,
    bus_timer_if.slave bus,
    output logic       irq
);
    logic        start, periodic, flag;
    logic        acc, wr, match;
    logic        wr_ctrl, wr_intr, wr_expr, wr_cnt;
    logic [31:0] expr, count, rd_mux;
    assign acc     = !bus.cs_ && !bus.as_;
    assign wr      = acc && !bus.rw;
    assign wr_ctrl = wr && bus.addr == 2'd0;
    assign wr_intr = wr && bus.addr == 2'd1;
    assign wr_expr = wr && bus.addr == 2'd2;
    assign wr_cnt  = wr && bus.addr == 2'd3;
    assign match   = start && count == expr;
    assign irq     = flag;
    always_comb
        rd_mux = bus.addr == 2'd0 ? {30'd0, periodic, start} :
                 bus.addr == 2'd1 ? {31'd0, flag} :
                 bus.addr == 2'd2 ? expr : count;
    // bus writes win over expiry except for the flag, where the set wins
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            start       <= 1'b0;
            periodic    <= 1'b0;
            flag        <= 1'b0;
            expr        <= 32'd0;
            count       <= 32'd0;
            bus.rd_data <= 32'd0;
            bus.rdy_    <= 1'b1;
        end else begin
            start       <= wr_ctrl ? bus.wr_data[0] : start && !(match && !periodic);
            periodic    <= wr_ctrl ? bus.wr_data[1] : periodic;
            flag        <= match ? 1'b1 : wr_intr ? bus.wr_data[0] : flag;
            expr        <= wr_expr ? bus.wr_data : expr;
            count       <= wr_cnt ? bus.wr_data : match ? 32'd0 : start ? count + 32'd1 : count;
            bus.rd_data <= acc && bus.rw ? rd_mux : 32'd0;
            bus.rdy_    <= !acc;
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed checks of bus_timer registers, counting, expiry and collisions
module tb_bus_timer;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    logic irq;
    int checks = 0;
    int errors = 0;
    bus_timer_if bus ();
    bus_timer dut (.clk(clk), .reset_(reset_), .bus(bus), .irq(irq));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic rw, input logic [1:0] a, input logic [31:0] d);
        bus.cs_ = 1'b0;
        bus.as_ = 1'b0;
        bus.rw = rw;
        bus.addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.cs_ = 1'b1;
        bus.as_ = 1'b1;
        bus.rw = 1'b1;
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive(1'b0, a, d);
        chk("wr_rdy", {31'd0, bus.rdy_}, 32'd0);
        chk("wr_rdata", bus.rd_data, 32'd0);
    endtask
    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        drive(1'b1, a, 32'd0);
        chk({tag, "_rdy"}, {31'd0, bus.rdy_}, 32'd0);
        chk(tag, bus.rd_data, exp);
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.cs_ = 1'b1;
        bus.as_ = 1'b1;
        bus.rw = 1'b1;
        bus.addr = 2'd0;
        bus.wr_data = 32'd0;
        idle(2);
        reset_ = 1'b1;
        idle(1);
        // reset mid-access with irq raised and a read response in flight
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd5);
        chk("pre_irq", {31'd0, irq}, 32'd1);
        bus.cs_ = 1'b0;
        bus.as_ = 1'b0;
        bus.rw = 1'b1;
        bus.addr = 2'd2;
        @(posedge clk);
        #1;
        chk("pre_rst_rdy", {31'd0, bus.rdy_}, 32'd0);
        chk("pre_rst_rdata", bus.rd_data, 32'd5);
        reset_ = 1'b0;
        #1;
        chk("rst_rdy", {31'd0, bus.rdy_}, 32'd1);
        chk("rst_rdata", bus.rd_data, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        bus.cs_ = 1'b1;
        bus.as_ = 1'b1;
        @(negedge clk);
        reset_ = 1'b1;
        idle(1);
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_intr", 2'd1, 32'd0);
        rd("rst_expr", 2'd2, 32'd0);
        rd("rst_cnt", 2'd3, 32'd0);
        // register round trip
        wr(2'd2, 32'hDEADBEEF);
        rd("rt_expr", 2'd2, 32'hDEADBEEF);
        idle(1);
        chk("rt_idle_rdy", {31'd0, bus.rdy_}, 32'd1);
        chk("rt_idle_rdata", bus.rd_data, 32'd0);
        wr(2'd0, 32'hFFFFFFFF);
        rd("rt_ctrl", 2'd0, 32'h3);
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0);
        // one-shot
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            rd("os_cnt", 2'd3, (i + 1) % 5);
            chk("os_irq", {31'd0, irq}, i >= 3 ? 32'd1 : 32'd0);
        end
        rd("os_ctrl", 2'd0, 32'h0);
        rd("os_hold", 2'd3, 32'h0);
        rd("os_intr", 2'd1, 32'h1);
        wr(2'd1, 32'h0);
        chk("os_clr_irq", {31'd0, irq}, 32'd0);
        // periodic
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h3);
        for (int i = 0; i < 6; i++) rd("per_cnt", 2'd3, i % 3);
        chk("per_irq", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'h0);
        chk("per_clr", {31'd0, irq}, 32'd0);
        rd("per_cnt2", 2'd3, 32'd1);
        wr(2'd1, 32'h0);
        chk("per_clr_collide", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h0);
        // wrap-around
        wr(2'd2, 32'd1);
        wr(2'd3, 32'hFFFFFFFE);
        wr(2'd0, 32'h1);
        idle(1);
        rd("wrap_ff", 2'd3, 32'hFFFFFFFF);
        chk("wrap_irq0", {31'd0, irq}, 32'd0);
        rd("wrap_0", 2'd3, 32'h0);
        rd("wrap_1", 2'd3, 32'h1);
        chk("wrap_irq1", {31'd0, irq}, 32'd1);
        rd("wrap_exp", 2'd3, 32'h0);
        // collision: counter write during expiry
        wr(2'd1, 32'h0);
        wr(2'd2, 32'd2);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        idle(2);
        wr(2'd3, 32'h100);
        chk("col_cnt_irq", {31'd0, irq}, 32'd1);
        rd("col_cnt", 2'd3, 32'h100);
        rd("col_cnt_ctrl", 2'd0, 32'h0);
        // collision: ctrl write during one-shot expiry
        wr(2'd1, 32'h0);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        idle(2);
        wr(2'd0, 32'h1);
        chk("col_ctrl_irq", {31'd0, irq}, 32'd1);
        rd("col_ctrl", 2'd0, 32'h1);
        rd("col_ctrl_cnt", 2'd3, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped timer peripheral acting as a responder on the simple bus: the slave end of the transaction that the CPU memory stage initiates through its address strobe, read/write flag and write data. It holds four 32-bit registers (control, interrupt flag, expiry value, counter), answers each selected bus cycle with a one-cycle `rdy_` pulse and registered read data, and raises a level interrupt when the free-running counter reaches the expiry value.

## Interface

Parameters: none; register map and widths are fixed.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `cs_` in 1: chip select from the bus address decoder, active-low.
- `as_` in 1: address strobe, active-low; an access occurs when `cs_` = 0 and `as_` = 0.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 2: word index of the register (0 CTRL, 1 INTR, 2 EXPR, 3 COUNTER).
- `wr_data` in 32: write data.
- `rd_data` out 32: read data, registered.
- `rdy_` out 1: ready, active-low, registered.
- `irq` out 1: interrupt request, active-high level, equal to INTR.flag.

## Operation

- Access: `acc` = !`cs_` & !`as_`.
- Registers:
  - CTRL: bit0 `start`, bit1 `periodic`; bits 31:2 read as 0, writes ignored.
  - INTR: bit0 `flag`; bits 31:1 read as 0.
  - EXPR: 32-bit expiry value.
  - COUNTER: 32-bit count.
- Write (`acc` & `rw` = 0):
  - CTRL.start/periodic <= `wr_data[1:0]`.
  - INTR.flag <= `wr_data[0]`. Software clears the flag by writing 0.
  - EXPR <= `wr_data`.
  - COUNTER <= `wr_data`.
- Read (`acc` & `rw` = 1): selected register value, zero-extended, as sampled before the same edge's update.
- Counting: when `start` = 1 each cycle:
  - If COUNTER == EXPR: expiry. COUNTER <= 0 and flag <= 1. If `periodic` = 0, start <= 0.
  - Otherwise COUNTER <= COUNTER + 1, mod 2^32. With EXPR < COUNTER, the counter wraps through 0xFFFFFFFF to 0 before matching.
  - When `start` = 0, COUNTER holds.
- Same-cycle priorities:
  - Bus write to COUNTER and expiry together: the written value wins; flag is still set.
  - Bus write to CTRL and one-shot expiry together: the written start/periodic values win.
  - Bus write of 0 to INTR and expiry together: set wins, flag = 1.
  - Bus write to EXPR: takes effect for the comparison on the next cycle. The current cycle compares against the old EXPR.
- Reset (`reset_` low, at any time, including mid-access): all registers 0, `rd_data` = 0, `rdy_` = 1, `irq` = 0. Any pending response is discarded.

## Timing

- Response latency: 1 cycle. An access sampled at edge N drives `rdy_` = 0 and `rd_data` during cycle N..N+1 only. The next cycle returns to `rdy_` = 1 and `rd_data` = 0 unless a new access was sampled.
- `rd_data` = 0 for write accesses and idle cycles.
- Back-to-back accesses on consecutive cycles are each answered, giving one `rdy_` low cycle per access.
- Write data is architecturally visible at the edge that samples the access. A read of the same register in the following cycle returns the new value.
- `irq` rises in the cycle after the matching edge: the edge where COUNTER == EXPR registers flag = 1.
- Period in periodic mode: EXPR+1 cycles between expiries.

## Test plan

- Reset values: assert `reset_` = 0 mid-access -> `rdy_` = 1, `rd_data` = 0, `irq` = 0 immediately; after release, reads of all four registers return 0.
- Register round trip: write EXPR = 0xDEADBEEF, then read EXPR -> `rdy_` low exactly one cycle after each access, `rd_data` = 0xDEADBEEF. Write CTRL = 0xFFFFFFFF -> read returns 0x00000003.
- One-shot: EXPR = 4, COUNTER = 0, CTRL = 0x1 -> COUNTER sequence 1,2,3,4,0. `irq` = 1 one cycle after the match, CTRL reads 0x0, COUNTER stays 0. Write INTR = 0 -> `irq` = 0 next cycle.
- Periodic: EXPR = 2, CTRL = 0x3 -> expiry every 3 cycles, COUNTER cycles 0,1,2,0. Clearing INTR in the exact expiry cycle leaves `irq` = 1.
- Wrap-around: COUNTER = 0xFFFFFFFE, EXPR = 1, start -> COUNTER goes 0xFFFFFFFF, 0, 1, then expiry, with `irq` = 1.
- Collisions: write COUNTER = 0x100 in the expiry cycle -> COUNTER = 0x100, `irq` = 1. Write CTRL = 0x1 in a one-shot expiry cycle -> start stays 1.
